eth_pcs_tx_seq: RTL

ETH_PCS_TX_SEQ -- requirements
Module: eth_pcs_tx_seq

---
 rtl/eth_pcs_params.sv | 12 +
 rtl/eth_pcs_tx_seq_if.sv | 13 +
 rtl/eth_pcs_tx_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/eth_pcs_params.sv
// eth_pcs_params: shared 10GBASE-R PCS lane geometry, XGMII control symbols and TX sequencer state type
package eth_pcs_params;
    localparam int N_CHANNELS      = 4;
    localparam int W_BYTE          = 8;
    localparam int N_TRANS_PER_BLK = 2;
    localparam int W_TRANS_PER_BLK = 1;
    localparam logic [W_BYTE-1:0] SYM_IDLE  = 8'h07;
    localparam logic [W_BYTE-1:0] SYM_START = 8'hFB;
    localparam logic [W_BYTE-1:0] SYM_TERM  = 8'hFD;
    localparam logic [W_BYTE-1:0] SYM_ERR   = 8'hFE;
    typedef enum logic [1:0] {WAIT, STABLE, RUN, ABORT} eth_pcs_tx_seq_state_t;
endpackage

// File: rtl/eth_pcs_tx_seq_if.sv
// eth_pcs_tx_seq_if: MAC word into the TX sequencer and the word it hands to the 64b/66b encoder
// Signals: i_mac_ctrl/i_mac_data MAC XGMII word; o_mac_ready word consumed;
//   o_xgmii_ctrl/o_xgmii_data word to encoder. master = MAC side, slave = sequencer.
interface eth_pcs_tx_seq_if;
    import eth_pcs_params::*;
    logic [N_CHANNELS-1:0]             i_mac_ctrl;
    logic [N_CHANNELS-1:0][W_BYTE-1:0] i_mac_data;
    logic                              o_mac_ready;
    logic [N_CHANNELS-1:0]             o_xgmii_ctrl;
    logic [N_CHANNELS-1:0][W_BYTE-1:0] o_xgmii_data;
    modport master (output i_mac_ctrl, i_mac_data, input o_mac_ready, o_xgmii_ctrl, o_xgmii_data);
    modport slave  (input i_mac_ctrl, i_mac_data, output o_mac_ready, o_xgmii_ctrl, o_xgmii_data);
endinterface

// File: rtl/eth_pcs_tx_seq.sv
// eth_pcs_tx_seq: gates MAC XGMII words into the 64b/66b encoder, pacing them with the gearbox pause
// Ports: i_clk, i_reset_n (async active-low); i_phy_tx_ready PMA ready; mac (slave) MAC word in,
//   encoder word out, o_mac_ready; o_clk_en/o_trans_cnt/o_blk_last encoder timing;
//   o_run high in RUN; o_tx_abort one-cycle pulse on entering ABORT.
module eth_pcs_tx_seq
    import eth_pcs_params::*;
#(
    parameter int PHY_STABLE_CYCLES = 16,
    parameter int PAUSE_PERIOD      = 33
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_phy_tx_ready,
    eth_pcs_tx_seq_if.slave            mac,
    output logic                       o_clk_en,
    output logic [W_TRANS_PER_BLK-1:0] o_trans_cnt,
    output logic                       o_blk_last,
    output logic                       o_run,
    output logic                       o_tx_abort
);
    localparam int W_PCNT = $clog2(PAUSE_PERIOD);
    localparam int W_STAB = $clog2(PHY_STABLE_CYCLES + 1);
    localparam logic [W_PCNT-1:0]          PCNT_LAST  = W_PCNT'(PAUSE_PERIOD - 1);
    localparam logic [W_STAB-1:0]          STAB_MAX   = W_STAB'(PHY_STABLE_CYCLES);
    localparam logic [W_TRANS_PER_BLK-1:0] TRANS_LAST = W_TRANS_PER_BLK'(N_TRANS_PER_BLK - 1);

    eth_pcs_tx_seq_state_t      state_q;
    logic [W_PCNT-1:0]          pcnt_q;
    logic [W_STAB-1:0]          stab_q;
    logic [W_TRANS_PER_BLK-1:0] trans_q;
    logic clk_en_q, in_frame_q, drop_q, tx_abort_q;
    logic blk_last, accept, has_start, has_term, in_frame_d, stop_req;

    assign blk_last  = clk_en_q && (trans_q == TRANS_LAST);
    assign accept    = clk_en_q && (state_q == RUN);
    assign has_start = mac.i_mac_ctrl[0] && (mac.i_mac_data[0] == SYM_START);

    always_comb begin
        has_term = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++)
            has_term = has_term | (mac.i_mac_ctrl[i] && (mac.i_mac_data[i] == SYM_TERM));
    end

    // TERM wins over START in the same word, so a one-word frame leaves in_frame clear.
    assign in_frame_d = !accept ? in_frame_q : has_term ? 1'b0 : has_start ? 1'b1 : in_frame_q;
    // A ready drop is remembered until the block boundary, even if ready recovers meanwhile.
    assign stop_req   = drop_q || !i_phy_tx_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= WAIT;
            pcnt_q     <= '0;
            clk_en_q   <= 1'b0;
            trans_q    <= '0;
            stab_q     <= '0;
            in_frame_q <= 1'b0;
            drop_q     <= 1'b0;
            tx_abort_q <= 1'b0;
        end else begin
            pcnt_q     <= (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
            clk_en_q   <= (pcnt_q != PCNT_LAST);
            trans_q    <= !clk_en_q ? trans_q : (trans_q == TRANS_LAST) ? '0 : trans_q + 1'b1;
            in_frame_q <= in_frame_d;
            tx_abort_q <= 1'b0;
            case (state_q)
                WAIT: if (i_phy_tx_ready) begin
                    state_q <= STABLE;
                    stab_q  <= '0;
                end
                STABLE: begin
                    if (!i_phy_tx_ready) state_q <= WAIT;
                    else if (stab_q != STAB_MAX) stab_q <= stab_q + 1'b1;
                    else if (blk_last) state_q <= RUN;
                end
                RUN: begin
                    drop_q <= stop_req;
                    if (blk_last && stop_req) begin
                        state_q    <= in_frame_d ? ABORT : WAIT;
                        tx_abort_q <= in_frame_d;
                        drop_q     <= 1'b0;
                    end
                end
                ABORT: if (blk_last) begin
                    state_q    <= WAIT;
                    in_frame_q <= 1'b0;
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    assign o_clk_en         = clk_en_q;
    assign o_trans_cnt      = trans_q;
    assign o_blk_last       = blk_last;
    assign o_run            = (state_q == RUN);
    assign o_tx_abort       = tx_abort_q;
    assign mac.o_mac_ready  = accept;
    assign mac.o_xgmii_ctrl = (state_q == RUN) ? mac.i_mac_ctrl : '1;
    assign mac.o_xgmii_data = (state_q == RUN) ? mac.i_mac_data
                            : {N_CHANNELS{(state_q == ABORT) ? SYM_ERR : SYM_IDLE}};
endmodule
